// File: rtl/eth_mii_tx_arbiter.sv
// Two-source MII transmit arbiter: round-robin per frame, emits preamble/SFD/payload nibbles
// (low nibble first) and enforces the inter-frame gap before re-arbitrating.
module eth_mii_tx_arbiter #(
    parameter int PRE_NIBBLES = 15,
    parameter int IFG_NIBBLES = 24
) (
    input  logic       eth_mac_clock,
    input  logic       eth_mac_rst,
    input  logic [7:0] src0_data,
    input  logic       src0_valid,
    input  logic       src0_last,
    output logic       src0_ready,
    input  logic [7:0] src1_data,
    input  logic       src1_valid,
    input  logic       src1_last,
    output logic       src1_ready,
    output logic [3:0] eth_mii_txd,
    output logic       eth_mii_tx_en,
    output logic       eth_mii_tx_er,
    output logic [1:0] grant,
    output logic       underrun
);

    localparam int CNT_MAX = (PRE_NIBBLES > IFG_NIBBLES) ? PRE_NIBBLES : IFG_NIBBLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREAMBLE,
        S_SFD,
        S_DATA_LO,
        S_DATA_HI,
        S_IFG
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [7:0]         r_hold;
    logic               r_hold_last;
    logic [1:0]         r_last_grant;
    logic [1:0]         r_grant;
    logic [3:0]         r_txd;
    logic               r_tx_en;
    logic               r_tx_er;
    logic               r_underrun;

    logic [1:0]         w_req;
    logic [1:0]         w_win;
    logic               w_fetch;
    logic               w_sel_valid;
    logic [7:0]         w_sel_data;
    logic               w_sel_last;

    assign w_req = {src1_valid, src0_valid};

    // On a tie the source that did not own the previous frame wins.
    always_comb begin
        w_win = w_req;
        if (w_req == 2'b11)
            w_win = (r_last_grant == 2'b01) ? 2'b10 : 2'b01;
    end

    assign w_fetch     = (r_state == S_SFD) || ((r_state == S_DATA_HI) && !r_hold_last);
    assign src0_ready  = r_grant[0] & w_fetch;
    assign src1_ready  = r_grant[1] & w_fetch;

    assign w_sel_valid = r_grant[1] ? src1_valid : src0_valid;
    assign w_sel_data  = r_grant[1] ? src1_data  : src0_data;
    assign w_sel_last  = r_grant[1] ? src1_last  : src0_last;

    always_ff @(posedge eth_mac_clock) begin
        if (eth_mac_rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_hold       <= '0;
            r_hold_last  <= 1'b0;
            r_last_grant <= 2'b10;
            r_grant      <= 2'b00;
            r_txd        <= 4'h0;
            r_tx_en      <= 1'b0;
            r_tx_er      <= 1'b0;
            r_underrun   <= 1'b0;
        end else begin
            r_underrun <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_txd   <= 4'h0;
                    r_tx_en <= 1'b0;
                    if (|w_req) begin
                        r_last_grant <= w_win;
                        r_grant      <= w_win;
                        r_tx_en      <= 1'b1;
                        r_txd        <= 4'h5;
                        r_cnt        <= CNT_W'(1);
                        r_state      <= S_PREAMBLE;
                    end
                end
                S_PREAMBLE: begin
                    if (r_cnt == CNT_W'(PRE_NIBBLES)) begin
                        r_txd   <= 4'hD;
                        r_state <= S_SFD;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_SFD, S_DATA_HI: begin
                    if ((r_state == S_DATA_HI) && r_hold_last) begin
                        r_tx_en <= 1'b0;
                        r_txd   <= 4'h0;
                        r_grant <= 2'b00;
                        r_cnt   <= CNT_W'(1);
                        r_state <= S_IFG;
                    end else if (w_sel_valid) begin
                        r_hold      <= w_sel_data;
                        r_hold_last <= w_sel_last;
                        r_txd       <= w_sel_data[3:0];
                        r_state     <= S_DATA_LO;
                    end else begin
                        // Error nibble keeps tx_en high; the gap count starts after it.
                        r_txd      <= 4'h0;
                        r_tx_er    <= 1'b1;
                        r_underrun <= 1'b1;
                        r_cnt      <= '0;
                        r_state    <= S_IFG;
                    end
                end
                S_DATA_LO: begin
                    r_txd   <= r_hold[7:4];
                    r_state <= S_DATA_HI;
                end
                S_IFG: begin
                    r_tx_en <= 1'b0;
                    r_tx_er <= 1'b0;
                    r_txd   <= 4'h0;
                    r_grant <= 2'b00;
                    if (r_cnt == CNT_W'(IFG_NIBBLES))
                        r_state <= S_IDLE;
                    else
                        r_cnt <= r_cnt + 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign eth_mii_txd   = r_txd;
    assign eth_mii_tx_en = r_tx_en;
    assign eth_mii_tx_er = r_tx_er;
    assign grant         = r_grant;
    assign underrun      = r_underrun;

endmodule

// File: tb/tb_eth_mii_tx_arbiter.sv
// Bench for eth_mii_tx_arbiter: frame-level scoreboard of expected nibble streams, grant,
// error marking and inter-frame gaps, fed by directed and randomized source traffic.
module tb_eth_mii_tx_arbiter;

    localparam int PRE = 15;
    localparam int IFG = 24;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] d0, d1;
    logic       v0, v1, l0, l1;
    logic       src0_ready, src1_ready;
    logic [3:0] txd;
    logic       tx_en, tx_er, underrun;
    logic [1:0] grant;

    always #5 clk = ~clk;

    eth_mii_tx_arbiter #(.PRE_NIBBLES(PRE), .IFG_NIBBLES(IFG)) dut (
        .eth_mac_clock (clk),
        .eth_mac_rst   (rst),
        .src0_data     (d0),
        .src0_valid    (v0),
        .src0_last     (l0),
        .src0_ready    (src0_ready),
        .src1_data     (d1),
        .src1_valid    (v1),
        .src1_last     (l1),
        .src1_ready    (src1_ready),
        .eth_mii_txd   (txd),
        .eth_mii_tx_en (tx_en),
        .eth_mii_tx_er (tx_er),
        .grant         (grant),
        .underrun      (underrun)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: one header per expected frame plus a flat nibble stream.
    int         q_g[$];
    int         q_n[$];
    bit         q_er[$];
    bit         q_tr[$];
    bit         q_ex[$];
    logic [3:0] q_nib[$];
    int         model_last = 1;   // index of source that owned the previous frame

    task automatic push_frame(input int src, input logic [7:0] b[8], input int nb,
                              input bit urun, input bit trunc, input bit exact);
        q_g.push_back(src == 0 ? 1 : 2);
        q_n.push_back(PRE + 1 + 2 * nb + (urun ? 1 : 0));
        q_er.push_back(urun);
        q_tr.push_back(trunc);
        q_ex.push_back(exact);
        for (int i = 0; i < PRE; i++) q_nib.push_back(4'h5);
        q_nib.push_back(4'hD);
        for (int i = 0; i < nb; i++) begin
            q_nib.push_back(b[i][3:0]);
            q_nib.push_back(b[i][7:4]);
        end
        if (urun) q_nib.push_back(4'h0);
    endtask

    // Source drivers
    int acc[2];
    bit abort_src[2];

    task automatic set_src(input int src, input logic v, input logic [7:0] d, input logic l);
        if (src == 0) begin v0 = v; d0 = d; l0 = l; end
        else          begin v1 = v; d1 = d; l1 = l; end
    endtask

    task automatic send(input int src, input logic [7:0] b[8], input int nb, input bit urun);
        for (int i = 0; i < nb; i++) begin
            int  t;
            bit  done;
            logic rdy;
            t = 0;
            done = 0;
            set_src(src, 1'b1, b[i], (i == nb - 1) && !urun);
            while (!done) begin
                @(negedge clk);
                if (abort_src[src]) begin
                    set_src(src, 1'b0, 8'h00, 1'b0);
                    return;
                end
                rdy = (src == 0) ? src0_ready : src1_ready;
                if (rdy) begin
                    @(posedge clk);
                    #1;
                    acc[src]++;
                    done = 1;
                end else if (++t > 3000) begin
                    chk("driver_accept_timeout", 0, 1);
                    set_src(src, 1'b0, 8'h00, 1'b0);
                    return;
                end
            end
        end
        set_src(src, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic single(input int src, input logic [7:0] b[8], input int nb,
                          input bit urun, input bit exact);
        push_frame(src, b, nb, urun, 1'b0, exact);
        model_last = src;
        send(src, b, nb, urun);
    endtask

    // Both sources request on the same cycle while the arbiter is idle.
    task automatic tie(input logic [7:0] ba[8], input int na, input bit ua,
                       input logic [7:0] bb[8], input int nbb, input bit ub);
        int first;
        first = 1 - model_last;
        if (first == 0) begin
            push_frame(0, ba, na, ua, 1'b0, 1'b0);
            push_frame(1, bb, nbb, ub, 1'b0, 1'b1);
        end else begin
            push_frame(1, bb, nbb, ub, 1'b0, 1'b0);
            push_frame(0, ba, na, ua, 1'b0, 1'b1);
        end
        model_last = 1 - first;
        fork
            send(0, ba, na, ua);
            send(1, bb, nbb, ub);
        join
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        model_last = 1;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (q_g.size() != 0 && t < 3000) begin @(negedge clk); t++; end
        if (q_g.size() != 0) chk("frame_start_timeout", q_g.size(), 0);
        t = 0;
        @(negedge clk);
        while (tx_en && t < 3000) begin @(negedge clk); t++; end
        if (tx_en) chk("frame_end_timeout", 1, 0);
        repeat (IFG + 4) @(posedge clk);
    endtask

    // Monitor: checks every cycle at the falling edge against the scoreboard.
    initial begin
        int         cg, cn, idx, gap;
        bit         cer, ctr, cex, in_f, have_prev, skip_gap, er_now;
        logic [3:0] cur[64];
        cg = 0; cn = 0; idx = 0; gap = 0;
        cer = 0; ctr = 0; cex = 0; in_f = 0; have_prev = 0; skip_gap = 0;
        forever begin
            @(negedge clk);
            if (rst) skip_gap = 1;
            if (src0_ready || src1_ready) begin
                chk("ready_owner", int'({src1_ready, src0_ready} & ~grant), 0);
                chk("ready_tx_en", int'(tx_en), 1);
            end
            if (tx_en) begin
                if (!in_f) begin
                    in_f = 1;
                    idx = 0;
                    if (q_g.size() == 0) begin
                        chk("unexpected_frame", 1, 0);
                        cg = 0; cn = 0; cer = 0; ctr = 0; cex = 0;
                    end else begin
                        cg = q_g.pop_front();
                        cn = q_n.pop_front();
                        cer = q_er.pop_front();
                        ctr = q_tr.pop_front();
                        cex = q_ex.pop_front();
                        for (int i = 0; i < cn; i++) cur[i] = q_nib.pop_front();
                    end
                    if (have_prev && !skip_gap) begin
                        if (cex) chk("gap_exact", gap, IFG + 1);
                        else     chk("gap_min", int'(gap >= IFG + 1), 1);
                    end
                    skip_gap = 0;
                end
                chk("grant", int'(grant), cg);
                if (idx < cn) chk("txd", int'(txd), int'(cur[idx]));
                else          chk("frame_too_long", idx + 1, cn);
                er_now = cer && (idx == cn - 1);
                chk("tx_er", int'(tx_er), int'(er_now));
                chk("underrun", int'(underrun), int'(er_now));
                idx++;
            end else begin
                chk("idle_outputs", int'({tx_er, underrun, grant, txd}), 0);
                if (in_f) begin
                    in_f = 0;
                    if (ctr) chk("trunc_len", int'(idx <= cn), 1);
                    else     chk("frame_len", idx, cn);
                    have_prev = 1;
                    gap = 1;
                end else begin
                    gap++;
                end
            end
        end
    end

    logic [7:0] b0[8];
    logic [7:0] b1[8];

    initial begin
        rst = 1'b1;
        set_src(0, 1'b0, 8'h00, 1'b0);
        set_src(1, 1'b0, 8'h00, 1'b0);
        abort_src[0] = 0;
        abort_src[1] = 0;
        acc[0] = 0;
        acc[1] = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_tx_en", int'(tx_en), 0);
        chk("rst_txd", int'(txd), 0);
        chk("rst_grant_er_urun", int'({grant, tx_er, underrun}), 0);
        chk("rst_ready", int'({src1_ready, src0_ready}), 0);

        // Single frame from src0
        b0[0] = 8'hA5; b0[1] = 8'h3C;
        single(0, b0, 2, 1'b0, 1'b0);
        wait_idle();
        chk("t1_src0_accepts", acc[0], 2);
        chk("t1_src1_accepts", acc[1], 0);

        // Contention after reset, then a second tie
        do_reset();
        b0[0] = 8'h12; b1[0] = 8'h34;
        tie(b0, 1, 1'b0, b1, 1, 1'b0);
        wait_idle();
        b0[0] = 8'h56; b1[0] = 8'h78;
        tie(b0, 1, 1'b0, b1, 1, 1'b0);
        wait_idle();

        // Underrun on src1
        b1[0] = 8'h11;
        single(1, b1, 1, 1'b1, 1'b0);
        wait_idle();

        // Reset in the middle of a src1 frame
        for (int i = 0; i < 6; i++) b1[i] = 8'(8'h90 + i);
        push_frame(1, b1, 6, 1'b0, 1'b1, 1'b0);
        fork
            send(1, b1, 6, 1'b0);
            begin
                int t;
                t = 0;
                @(negedge clk);
                while (!src1_ready && t < 200) begin @(negedge clk); t++; end
                chk("t4_src1_fetch_seen", int'(src1_ready), 1);
                repeat (3) @(posedge clk);
                #1 rst = 1'b1;
                abort_src[1] = 1;
                @(posedge clk);
                #1 rst = 1'b0;
                abort_src[1] = 0;
            end
        join
        model_last = 1;
        @(negedge clk);
        chk("t4_rst_outs", int'({tx_en, tx_er, underrun, grant, txd}), 0);
        repeat (3) @(posedge clk);
        #1;
        b0[0] = 8'hC3; b1[0] = 8'h3C;
        tie(b0, 1, 1'b0, b1, 1, 1'b0);
        wait_idle();

        // Request raised during the inter-frame gap
        b0[0] = 8'h77;
        single(0, b0, 1, 1'b0, 1'b0);
        begin
            int t;
            t = 0;
            @(negedge clk);
            while (tx_en && t < 200) begin @(negedge clk); t++; end
            chk("t5_tx_en_low", int'(tx_en), 0);
        end
        b0[0] = 8'h88;
        single(0, b0, 1, 1'b0, 1'b1);
        wait_idle();

        // Back-to-back frames from src0 only
        for (int k = 0; k < 3; k++) begin
            b0[0] = 8'(8'hE0 + k);
            single(0, b0, 1, 1'b0, k > 0);
        end
        wait_idle();

        // Randomized traffic
        for (int it = 0; it < 10; it++) begin
            int mode, n0, n1;
            bit u0, u1;
            mode = $urandom_range(0, 2);
            n0 = $urandom_range(1, 4);
            n1 = $urandom_range(1, 4);
            u0 = ($urandom_range(0, 4) == 0);
            u1 = ($urandom_range(0, 4) == 0);
            for (int i = 0; i < 8; i++) begin
                b0[i] = 8'($urandom);
                b1[i] = 8'($urandom);
            end
            case (mode)
                0:       single(0, b0, n0, u0, 1'b0);
                1:       single(1, b1, n1, u1, 1'b0);
                default: tie(b0, n0, u0, b1, n1, u1);
            endcase
            wait_idle();
        end

        chk("scoreboard_empty", q_g.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
